// File: rtl/iob_except_scan_if.sv
// rtl/iob_except_scan_if.sv - retire request, exception RAM read port and scan result bundle
interface iob_except_scan_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [5:0]            in_row;
    logic [9:0]            in_mask;
    logic                  kill;

    logic                  read_step;
    logic [5:0]            read_addr;
    logic [DATA_WIDTH-1:0] read_data0;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic [DATA_WIDTH-1:0] read_data3;
    logic [DATA_WIDTH-1:0] read_data4;
    logic [DATA_WIDTH-1:0] read_data5;
    logic [DATA_WIDTH-1:0] read_data6;
    logic [DATA_WIDTH-1:0] read_data7;
    logic [DATA_WIDTH-1:0] read_data8;
    logic [DATA_WIDTH-1:0] read_data9;

    logic                  out_valid;
    logic                  out_ready;
    logic [5:0]            out_row;
    logic [9:0]            out_ok_mask;
    logic                  out_exc;
    logic [3:0]            out_exc_slot;
    logic [DATA_WIDTH-1:0] out_exc_data;
    logic [15:0]           exc_count;

    modport slave (
        input  in_valid, in_row, in_mask, kill,
        input  read_data0, read_data1, read_data2, read_data3, read_data4,
        input  read_data5, read_data6, read_data7, read_data8, read_data9,
        input  out_ready,
        output in_ready, read_step, read_addr,
        output out_valid, out_row, out_ok_mask, out_exc, out_exc_slot, out_exc_data, exc_count
    );

    modport master (
        output in_valid, in_row, in_mask, kill,
        output read_data0, read_data1, read_data2, read_data3, read_data4,
        output read_data5, read_data6, read_data7, read_data8, read_data9,
        output out_ready,
        input  in_ready, read_step, read_addr,
        input  out_valid, out_row, out_ok_mask, out_exc, out_exc_slot, out_exc_data, exc_count
    );
endinterface

// File: rtl/iob_except_scan.sv
// rtl/iob_except_scan.sv - retire-side scan of one ROB row's exception words for the first trap
module iob_except_scan #(
    parameter int DATA_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    iob_except_scan_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, SCAN, RESP} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [5:0]            addr_q;
    logic [9:0]            mask_q;
    logic [5:0]            row_q;
    logic [9:0]            ok_q;
    logic                  exc_q;
    logic [3:0]            slot_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [15:0]           cnt_q;

    logic                  in_ready;
    logic                  accept;
    logic [DATA_WIDTH-1:0] words [10];
    logic [9:0]            scan_ok;
    logic                  scan_exc;
    logic [3:0]            scan_slot;
    logic [DATA_WIDTH-1:0] scan_data;

    assign words[0] = bus.read_data0;
    assign words[1] = bus.read_data1;
    assign words[2] = bus.read_data2;
    assign words[3] = bus.read_data3;
    assign words[4] = bus.read_data4;
    assign words[5] = bus.read_data5;
    assign words[6] = bus.read_data6;
    assign words[7] = bus.read_data7;
    assign words[8] = bus.read_data8;
    assign words[9] = bus.read_data9;

    always_comb begin : fsm_next
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            RESP:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
        if (bus.kill) begin
            in_ready = 1'b0;
        end
        accept = bus.in_valid && in_ready;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = SCAN;
            SCAN:    state_d = RESP;
            RESP:    if (bus.out_ready) state_d = accept ? READ : IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill) begin
            state_d = IDLE;
        end
    end

    // Descending walk so the lowest flagged, valid slot is the one that sticks.
    always_comb begin : scan_first
        scan_ok   = mask_q;
        scan_exc  = 1'b0;
        scan_slot = 4'd0;
        scan_data = '0;
        for (int k = 9; k >= 0; k--) begin
            if (mask_q[k] && words[k][0]) begin
                scan_exc  = 1'b1;
                scan_slot = 4'(k);
                scan_data = words[k];
                scan_ok   = mask_q & ((10'd1 << k) - 10'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            row_q   <= '0;
            ok_q    <= '0;
            exc_q   <= 1'b0;
            slot_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= bus.in_row;
                mask_q <= bus.in_mask;
            end
            if (state_q == SCAN && !bus.kill) begin
                row_q  <= addr_q;
                ok_q   <= scan_ok;
                exc_q  <= scan_exc;
                slot_q <= scan_slot;
                data_q <= scan_data;
            end
            if (state_q == RESP && bus.out_ready && !bus.kill && exc_q && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.read_step    = (state_q == READ);
    assign bus.read_addr    = addr_q;
    assign bus.out_valid    = (state_q == RESP);
    assign bus.out_row      = row_q;
    assign bus.out_ok_mask  = ok_q;
    assign bus.out_exc      = exc_q;
    assign bus.out_exc_slot = slot_q;
    assign bus.out_exc_data = data_q;
    assign bus.exc_count    = cnt_q;
endmodule

// File: tb/tb_iob_except_scan.sv
// tb/tb_iob_except_scan.sv - randomized self-checking bench for iob_except_scan
module tb_iob_except_scan;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_count = 0;

    logic [15:0] mem [64][10];
    logic [5:0]  rd_row = '0;

    iob_except_scan_if #(.DATA_WIDTH(16)) bus ();

    iob_except_scan #(.DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.read_step) rd_row <= bus.read_addr;

    assign bus.read_data0 = mem[rd_row][0];
    assign bus.read_data1 = mem[rd_row][1];
    assign bus.read_data2 = mem[rd_row][2];
    assign bus.read_data3 = mem[rd_row][3];
    assign bus.read_data4 = mem[rd_row][4];
    assign bus.read_data5 = mem[rd_row][5];
    assign bus.read_data6 = mem[rd_row][6];
    assign bus.read_data7 = mem[rd_row][7];
    assign bus.read_data8 = mem[rd_row][8];
    assign bus.read_data9 = mem[rd_row][9];

    // Reference: isolate the lowest set bit of (mask & flags) arithmetically.
    function automatic void ref_scan(input logic [5:0] row, input logic [9:0] mask,
                                     output logic [9:0] ok, output logic exc,
                                     output logic [3:0] slot, output logic [15:0] data);
        logic [9:0] flags;
        logic [9:0] lowest;
        flags = '0;
        for (int i = 0; i < 10; i++) flags[i] = mem[row][i][0];
        flags = flags & mask;
        if (flags == 10'd0) begin
            ok = mask; exc = 1'b0; slot = 4'd0; data = 16'd0;
        end else begin
            lowest = flags & (~flags + 10'd1);
            slot   = 4'($clog2(lowest));
            ok     = mask & (lowest - 10'd1);
            exc    = 1'b1;
            data   = mem[row][slot];
        end
    endfunction

    function automatic logic [36:0] got_result();
        return {bus.out_row, bus.out_ok_mask, bus.out_exc, bus.out_exc_slot, bus.out_exc_data};
    endfunction

    // Called at a negedge with the DUT idle; runs one request through to acceptance.
    task automatic xact(input logic [5:0] row, input logic [9:0] mask);
        logic [9:0]  e_ok;
        logic        e_exc;
        logic [3:0]  e_slot;
        logic [15:0] e_data;
        ref_scan(row, mask, e_ok, e_exc, e_slot, e_data);
        bus.in_valid = 1'b1; bus.in_row = row; bus.in_mask = mask;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL xact_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.read_step !== 1'b1 || bus.read_addr !== row || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL xact_read: got step=%b addr=%0d ov=%b want step=1 addr=%0d ov=0",
                     bus.read_step, bus.read_addr, bus.out_valid, row);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.read_step !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL xact_scan: got step=%b ov=%b want 0 0", bus.read_step, bus.out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || got_result() !== {row, e_ok, e_exc, e_slot, e_data}) begin
            n_bad++;
            $display("FAIL xact_result row=%0d mask=%h: got ov=%b res=%h want ov=1 res=%h",
                     row, mask, bus.out_valid, got_result(), {row, e_ok, e_exc, e_slot, e_data});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (e_exc && exp_count < 65535) exp_count++;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.exc_count !== 16'(exp_count)) begin
            n_bad++;
            $display("FAIL xact_count: got ov=%b cnt=%0d want ov=0 cnt=%0d", bus.out_valid, bus.exc_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.read_step, bus.read_addr, got_result(), bus.exc_count} !== 61'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0",
                              {bus.out_valid, bus.read_step, bus.read_addr, got_result(), bus.exc_count});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        for (int k = 0; k < 10; k++) begin
            mem[5][k]  = 16'($urandom) & 16'hFFFE;
            mem[12][k] = 16'($urandom) & 16'hFFFE;
            mem[20][k] = 16'($urandom) & 16'hFFFE;
            mem[40][k] = 16'($urandom) & 16'hFFFE;
        end
        mem[12][3] = 16'h12AB;
        mem[12][7] = mem[12][7] | 16'h0001;
        mem[20][2] = mem[20][2] | 16'h0001;
        mem[20][6] = mem[20][6] | 16'h0001;
        mem[40][9] = 16'hBEEF;
        xact(6'd5, 10'h3FF);
        xact(6'd12, 10'h3FF);
        xact(6'd20, 10'h3F0);
        xact(6'd12, 10'h000);
        xact(6'd40, 10'h3FF);
        xact(6'd40, 10'h1FF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] r;
            logic [9:0] m;
            r = 6'($urandom_range(0, 63));
            m = (n % 4 == 0) ? 10'h3FF : 10'($urandom);
            for (int k = 0; k < 10; k++) begin
                mem[r][k]    = 16'($urandom);
                mem[r][k][0] = ($urandom_range(0, 4) == 0);
            end
            xact(r, m);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  a_ok, b_ok;
        logic        a_exc, b_exc;
        logic [3:0]  a_slot, b_slot;
        logic [15:0] a_data, b_data;
        ref_scan(6'd12, 10'h3FF, a_ok, a_exc, a_slot, a_data);
        ref_scan(6'd20, 10'h3F0, b_ok, b_exc, b_slot, b_data);
        bus.in_valid = 1'b1; bus.in_row = 6'd12; bus.in_mask = 10'h3FF;
        @(negedge clk);
        bus.in_row = 6'd20; bus.in_mask = 10'h3F0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy_ready: got %b want 0", bus.in_ready);
        end
        repeat (2) @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                got_result() !== {6'd12, a_ok, a_exc, a_slot, a_data}) begin
                n_bad++;
                $display("FAIL b2b_hold cycle %0d: got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=%h",
                         c, bus.out_valid, bus.in_ready, got_result(), {6'd12, a_ok, a_exc, a_slot, a_data});
            end
            if (c < 5) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_release_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        if (a_exc && exp_count < 65535) exp_count++;
        n_cmp++;
        if (bus.read_step !== 1'b1 || bus.read_addr !== 6'd20 || bus.out_valid !== 1'b0 ||
            bus.exc_count !== 16'(exp_count)) begin
            n_bad++;
            $display("FAIL b2b_chain: got step=%b addr=%0d ov=%b cnt=%0d want step=1 addr=20 ov=0 cnt=%0d",
                     bus.read_step, bus.read_addr, bus.out_valid, bus.exc_count, exp_count);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || got_result() !== {6'd20, b_ok, b_exc, b_slot, b_data}) begin
            n_bad++; $display("FAIL b2b_second: got ov=%b res=%h want ov=1 res=%h",
                              bus.out_valid, got_result(), {6'd20, b_ok, b_exc, b_slot, b_data});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        if (b_exc && exp_count < 65535) exp_count++;
    endtask

    task automatic test_kill();
        bus.in_valid = 1'b1; bus.in_row = 6'd12; bus.in_mask = 10'h3FF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.read_step !== 1'b0) begin
            n_bad++; $display("FAIL kill_scan: got ov=%b rdy=%b step=%b want 0 1 0",
                              bus.out_valid, bus.in_ready, bus.read_step);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.exc_count !== 16'(exp_count)) begin
            n_bad++; $display("FAIL kill_no_output: got ov=%b cnt=%0d want 0 %0d",
                              bus.out_valid, bus.exc_count, exp_count);
        end
        bus.kill = 1'b1; bus.in_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL kill_blocks_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        bus.kill = 1'b0; bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.read_step !== 1'b0) begin
            n_bad++; $display("FAIL kill_no_accept: got step=%b want 0", bus.read_step);
        end
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.kill = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.exc_count !== 16'(exp_count)) begin
            n_bad++; $display("FAIL kill_resp: got ov=%b cnt=%0d want 0 %0d",
                              bus.out_valid, bus.exc_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        xact(6'd12, 10'h3FF);
        bus.in_valid = 1'b1; bus.in_row = 6'd33; bus.in_mask = 10'h3FF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.read_step, bus.read_addr, got_result(), bus.exc_count} !== 61'd0) begin
            n_bad++; $display("FAIL reset_mid: got %h want 0",
                              {bus.out_valid, bus.read_step, bus.read_addr, got_result(), bus.exc_count});
        end
        @(negedge clk);
        rst = 1'b1;
        exp_count = 0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_mid_idle: got ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        xact(6'd20, 10'h3F0);
    endtask

    task automatic test_saturate();
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        exp_count = 65533;
        for (int n = 0; n < 4; n++) xact(6'd12, 10'h3FF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_row = '0; bus.in_mask = '0;
        bus.kill = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b0;
        for (int r = 0; r < 64; r++)
            for (int k = 0; k < 10; k++) mem[r][k] = 16'($urandom);
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
